// File: rtl/qnigma_sub_serial.sv
// Multi-precision serial subtractor: Q = A - B - c_in over N limbs of W bits, LSB limb first.
// A single output register with pass-through ready; the final borrow flags A < B (+c_in).
module qnigma_sub_serial #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         in_val,
    output logic         in_rdy,
    output logic [W-1:0] q,
    output logic         q_val,
    input  logic         q_rdy,
    output logic         q_last,
    output logic         q_brw
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_brw;
    logic [W-1:0]    r_q;
    logic            r_qval;
    logic            r_qlast;
    logic            r_qbrw;

    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_bin;
    logic            w_last;
    logic [W:0]      w_diff;

    assign in_rdy     = !r_qval || q_rdy;
    assign w_in_xfer  = in_val && in_rdy;
    assign w_out_xfer = r_qval && q_rdy;

    // IDLE always coincides with counter 0, so it marks limb 0 where c_in seeds the borrow.
    assign w_bin  = (r_state == S_IDLE) ? c_in : r_brw;
    assign w_last = (r_cnt == CW'(N - 1));
    assign w_diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, w_bin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_q     <= '0;
            r_qval  <= 1'b0;
            r_qlast <= 1'b0;
            r_qbrw  <= 1'b0;
        end else if (w_in_xfer) begin
            r_q    <= w_diff[W-1:0];
            r_brw  <= w_diff[W];
            r_qval <= 1'b1;
            if (w_last) begin
                r_qlast <= 1'b1;
                r_qbrw  <= w_diff[W];
                r_cnt   <= '0;
                r_state <= S_IDLE;
            end else begin
                r_qlast <= 1'b0;
                r_qbrw  <= 1'b0;
                r_cnt   <= r_cnt + CW'(1);
                r_state <= S_RUN;
            end
        end else if (w_out_xfer) begin
            // Drained with nothing behind it: the borrow flag must read 0 while q is invalid.
            r_qval  <= 1'b0;
            r_qlast <= 1'b0;
            r_qbrw  <= 1'b0;
        end
    end

    assign q      = r_q;
    assign q_val  = r_qval;
    assign q_last = r_qlast;
    assign q_brw  = r_qbrw;

endmodule

// File: tb/tb_qnigma_sub_serial.sv
// Scoreboard bench for qnigma_sub_serial: a W=16/N=4 instance and a W=8/N=1 instance.
module tb_qnigma_sub_serial;

    typedef struct packed {
        logic [15:0] q;
        logic        last;
        logic        brw;
    } exp_t;

    typedef struct packed {
        logic [7:0] q;
        logic       last;
        logic       brw;
    } exp8_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b, q;
    logic        c_in, in_val, in_rdy, q_val, q_rdy, q_last, q_brw;
    logic [7:0]  a8, b8, q8;
    logic        c_in8, in_val8, in_rdy8, q_val8, q_rdy8, q_last8, q_brw8;

    int checks   = 0;
    int failures = 0;
    int stall    = 0;
    bit rdy_mode = 0;

    exp_t  sb[$];
    exp8_t sb8[$];

    always #5 clk = ~clk;

    qnigma_sub_serial #(.W(16), .N(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_val(in_val), .in_rdy(in_rdy),
        .q(q), .q_val(q_val), .q_rdy(q_rdy), .q_last(q_last), .q_brw(q_brw)
    );

    qnigma_sub_serial #(.W(8), .N(1)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(c_in8), .in_val(in_val8), .in_rdy(in_rdy8),
        .q(q8), .q_val(q_val8), .q_rdy(q_rdy8), .q_last(q_last8), .q_brw(q_brw8)
    );

    function automatic logic [64:0] ref_sub(input logic [63:0] ra, input logic [63:0] rb, input logic rc);
        return {1'b0, ra} - {1'b0, rb} - {64'd0, rc};
    endfunction

    // Output monitor for the wide instance: handshake rule, stall stability, scoreboard pop.
    logic        prev_stall = 1'b0;
    logic [18:0] prev_out;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (in_rdy === (!q_val || q_rdy)) else begin
                failures++; $error("FAIL in_rdy got=%b exp=%b", in_rdy, (!q_val || q_rdy));
            end
            if (!(q_val && q_last)) begin
                checks++;
                assert (q_brw === 1'b0) else begin
                    failures++; $error("FAIL q_brw_idle got=%b exp=0", q_brw);
                end
            end
            if (prev_stall) begin
                checks++;
                assert ({q_val, q, q_last, q_brw} === prev_out) else begin
                    failures++; $error("FAIL stall_hold got=%h exp=%h", {q_val, q, q_last, q_brw}, prev_out);
                end
            end
            if (q_val && q_rdy) begin
                exp_t e;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $error("FAIL spurious_q got=%h exp=none", q);
                end else begin
                    e = sb.pop_front();
                    assert ({q, q_last, q_brw} === {e.q, e.last, e.brw}) else begin
                        failures++;
                        $error("FAIL q_limb got q=%h last=%b brw=%b exp q=%h last=%b brw=%b",
                               q, q_last, q_brw, e.q, e.last, e.brw);
                    end
                end
            end
            prev_stall = q_val && !q_rdy;
            prev_out   = {q_val, q, q_last, q_brw};
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && q_val8 && q_rdy8) begin
            exp8_t e;
            checks++;
            if (sb8.size() == 0) begin
                failures++; $error("FAIL spurious_q8 got=%h exp=none", q8);
            end else begin
                e = sb8.pop_front();
                assert ({q8, q_last8, q_brw8} === {e.q, e.last, e.brw}) else begin
                    failures++;
                    $error("FAIL q8_limb got q=%h last=%b brw=%b exp q=%h last=%b brw=%b",
                           q8, q_last8, q_brw8, e.q, e.last, e.brw);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rdy_mode) q_rdy = 1'b1;
        else if (stall > 0) begin q_rdy = 1'b0; stall--; end
        else q_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_limb(input logic [15:0] la, input logic [15:0] lb, input logic lc,
                             input exp_t e, input bit stall_after);
        bit acc = 0;
        int n = 0;
        a = la; b = lb; c_in = lc; in_val = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_rdy;
            if (acc) begin
                sb.push_back(e);
                if (stall_after) stall = 5;
            end
            tick();
            n++;
            if (!acc && n > 200) begin
                checks++; failures++;
                $display("FAIL accept_timeout got=no_accept exp=accept");
                $fatal(1, "input never accepted");
            end
        end
    endtask

    task automatic send_op(input logic [63:0] oa, input logic [63:0] ob, input logic cin0,
                           input logic cin_hi, input int nl, input bit gaps, input bit stall2);
        logic [64:0] d = ref_sub(oa, ob, cin0);
        exp_t e;
        for (int i = 0; i < nl; i++) begin
            if (gaps) begin
                in_val = 1'b0;
                a = 16'($urandom); b = 16'($urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
            e.q    = d[16*i +: 16];
            e.last = (i == 3);
            e.brw  = (i == 3) ? d[64] : 1'b0;
            send_limb(oa[16*i +: 16], ob[16*i +: 16], (i == 0) ? cin0 : cin_hi, e, stall2 && (i == 2));
        end
    endtask

    task automatic drain();
        int n = 0;
        in_val = 1'b0; in_val8 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'b1;
        while ((sb.size() != 0 || sb8.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        assert (sb.size() == 0 && sb8.size() == 0) else begin
            failures++; $error("FAIL drain got=%0d/%0d pending exp=0", sb.size(), sb8.size());
        end
    endtask

    task automatic send8(input logic [7:0] la, input logic [7:0] lb, input logic lc, input exp8_t e);
        a8 = la; b8 = lb; c_in8 = lc; in_val8 = 1'b1;
        @(negedge clk);
        checks++;
        assert (in_rdy8 === 1'b1) else begin
            failures++; $error("FAIL in_rdy8 got=%b exp=1", in_rdy8);
        end
        sb8.push_back(e);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_val = 1'b0; a = '0; b = '0; c_in = 1'b0; q_rdy = 1'b1;
        in_val8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; q_rdy8 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert ({q_val, q, q_last, q_brw} === 19'd0) else begin
            failures++; $error("FAIL reset_out got=%h exp=0", {q_val, q, q_last, q_brw});
        end
        checks++;
        assert ({q_val8, q8, q_last8, q_brw8} === 11'd0) else begin
            failures++; $error("FAIL reset_out8 got=%h exp=0", {q_val8, q8, q_last8, q_brw8});
        end
        tick();

        // Borrow ripple across all limbs.
        send_op(64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 4, 0, 0);
        drain();

        // Negative result, then equal operands back to back.
        send_op(64'h0, 64'h1, 1'b0, 1'b0, 4, 0, 0);
        send_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 4, 0, 0);
        drain();

        // c_in held high on every limb only counts once.
        send_op(64'h5, 64'h5, 1'b1, 1'b1, 4, 0, 0);
        drain();

        // Backpressure with input gaps and a long stall on limb 2.
        rdy_mode = 1;
        send_op(64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 4, 1, 1);
        send_op(64'hFFFF_0000_8000_0001, 64'h0000_FFFF_8000_0002, 1'b1, 1'b0, 4, 1, 0);
        send_op(64'h0, 64'h0, 1'b1, 1'b1, 4, 1, 0);
        drain();
        rdy_mode = 0;
        tick();

        // Reset mid-operand discards it and realigns to limb 0.
        send_op(64'h0, 64'h0, 1'b0, 1'b0, 2, 0, 0);
        in_val = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        assert ({q_val, q_last, q_brw} === 3'b000) else begin
            failures++; $error("FAIL mid_reset got=%b exp=000", {q_val, q_last, q_brw});
        end
        tick();
        send_op(64'h3, 64'h1, 1'b0, 1'b0, 4, 0, 0);
        drain();

        // Single-limb instance: every beat is last.
        send8(8'h00, 8'h01, 1'b0, '{q: 8'hFF, last: 1'b1, brw: 1'b1});
        send8(8'hFF, 8'h0F, 1'b0, '{q: 8'hF0, last: 1'b1, brw: 1'b0});
        send8(8'h80, 8'h80, 1'b1, '{q: 8'hFF, last: 1'b1, brw: 1'b1});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qnigma_sub_serial.md
Name: qnigma_sub_serial

Overview:
Multi-precision serial subtractor for the math library. Computes Q = A - B - c_in over operands of N limbs of W bits each, streamed least-significant limb first, one limb per accepted beat. Produces the difference limb stream and the final borrow, which is the A < B (+c_in) comparison flag. Used by modular reduction and comparison paths next to the existing adder.

Parameters:
W, 16, limb width in bits
N, 4, limbs per operand (N >= 1)
CW, $clog2(N) (minimum 1), limb counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
a  input  W  minuend limb
b  input  W  subtrahend limb
c_in  input  1  initial borrow; sampled only with limb 0
in_val  input  1  a/b/c_in valid
in_rdy  output  1  block accepts limb
q  output  W  difference limb
q_val  output  1  q valid
q_rdy  input  1  downstream accepts q
q_last  output  1  q is limb N-1
q_brw  output  1  final borrow; meaningful only when q_val && q_last, otherwise 0

Behaviour:
- Reset (rst=1 at a clk edge): q=0, q_val=0, q_last=0, q_brw=0, borrow register=0, limb counter=0, state=IDLE. Reset takes effect in any state. A partial operand in flight is discarded and no further output limbs of it appear. The next accepted limb is treated as limb 0.
- Handshake:
  - Input transfer when in_val && in_rdy. Output transfer when q_val && q_rdy.
  - in_rdy = !q_val || q_rdy. This is a single output register with pass-through ready, so there are no bubbles at full throughput.
  - q, q_last and q_brw hold stable while q_val && !q_rdy.
- Arithmetic per accepted limb:
  - bin = c_in if counter==0, else the borrow register.
  - diff[W:0] = {1'b0,a} - {1'b0,b} - bin.
  - q <= diff[W-1:0]. Borrow register <= diff[W].
  - Latency: input accept edge to q_val=1 is 1 cycle.
- FSM:
  - IDLE (counter=0): a transfer goes to RUN and counter becomes 1. If N==1, that transfer is also the last: stay in IDLE and set q_last.
  - RUN: each transfer increments counter. The transfer at counter==N-1 sets q_last=1, q_brw=diff[W], wraps counter to 0 and returns to IDLE.
- q_last and q_brw are cleared when a non-last limb is loaded.
- q_val: set on input transfer. Cleared on output transfer without a simultaneous input transfer. A simultaneous output and input transfer keeps q_val=1 with the new limb.
- No operand gap is required. Limb 0 of the next operand may be accepted on the cycle after the last limb, or the same cycle q_last drains.
- in_val low mid-operand: state and counter are held indefinitely, with no timeout.
- c_in is ignored for limbs 1..N-1. a, b and c_in are ignored whenever no input transfer occurs.
- Full wrap: A=0, B=0, c_in=1 yields all-ones limbs and q_brw=1. Results are modulo 2^(W*N), with q_brw as the sign.

Test Plan:
1. Borrow ripple. W=16, N=4, q_rdy=1. A limbs {0000,0000,0000,0001} (LSB first), B {0001,0000,0000,0000}, c_in=0 -> q {FFFF,FFFF,FFFF,0000}, q_last on beat 4, q_brw=0, one limb per cycle.
2. Negative result. A=0, B=1, c_in=0 -> q all FFFF, q_brw=1. Then A=B=0x1234_5678_9ABC_DEF0 back-to-back -> q all 0000, q_brw=0. The second operand starts the cycle after the first's last limb.
3. c_in handling. A=B=5 with c_in=1 on limb 0 and c_in=1 held on limbs 1..3 -> q all FFFF, q_brw=1. This proves c_in is used only at limb 0.
4. Backpressure. Random q_rdy (including 5 consecutive low cycles on limb 2) and random in_val gaps -> q stream identical to scenario 1. q and q_last are stable while stalled. in_rdy=0 exactly when q_val && !q_rdy. No limb is lost or duplicated.
5. Reset mid-operation. Accept limbs 0-1 of A=B=0, assert rst one cycle -> q_val=0 next cycle. Then send a full A=3, B=1 -> q {0002,0000,0000,0000}, q_brw=0. The stale counter must not shift limb alignment.
6. N=1, W=8. Pairs (0x00,0x01), (0xFF,0x0F), (0x80,0x80) with c_in 0,0,1 -> q 0xFF/0xF0/0xFF, q_brw 1/0/1, q_last=1 on every beat.
